// File: rtl/pc_pkg.sv
// pc_pkg
// Shared definitions for the program-counter / return-stack block:
// opcode encodings and the widths of the decode-side operands.
package pc_pkg;

  localparam int OPCODE_WIDTH   = 4;
  localparam int VALUE_WIDTH    = 8;
  localparam int REGISTER_WIDTH = 8;

  // NOP is not a real instruction; any unlisted code simply advances the PC.
  typedef enum logic [OPCODE_WIDTH-1:0] {
    NOP     = 4'h0,
    JUMP    = 4'h1,
    RJUMP   = 4'h2,
    CALL    = 4'h3,
    RET     = 4'h4,
    RETI    = 4'h5,
    IF0JUMP = 4'h6,
    IF1JUMP = 4'h7,
    RESET   = 4'h8
  } opcode_e;

endpackage

// File: rtl/pc_stack_unit_return_stack.sv
// pc_return_stack
// Parametrised LIFO holding return addresses.
//   clock, resetN : rising-edge clock, synchronous active-low reset
//   clear         : synchronous empty request (same effect as reset on depth)
//   push/pushData : write pushData at the current depth (ignored when full)
//   pop           : discard the top entry (ignored when empty)
//   topData       : combinational read of entry depth-1
//   depth         : number of valid entries
//   full/empty    : depth == DEPTH / depth == 0
module pc_return_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                         clock,
  input  logic                         resetN,
  input  logic                         clear,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             pushData,
  output logic [WIDTH-1:0]             topData,
  output logic [$clog2(DEPTH+1)-1:0]   depth,
  output logic                         full,
  output logic                         empty
);

  localparam int DEPTH_WIDTH = $clog2(DEPTH + 1);
  localparam int ADDR_WIDTH  = $clog2(DEPTH);

  logic [WIDTH-1:0]       mem [DEPTH];
  logic [DEPTH_WIDTH-1:0] count;
  logic [ADDR_WIDTH-1:0]  writeIndex;
  logic [ADDR_WIDTH-1:0]  topIndex;

  assign full       = (count == DEPTH_WIDTH'(DEPTH));
  assign empty      = (count == '0);
  assign depth      = count;
  assign writeIndex = ADDR_WIDTH'(count);
  // Guarding the empty case keeps the index in range for non power-of-two depths.
  assign topIndex   = empty ? '0 : ADDR_WIDTH'(count - DEPTH_WIDTH'(1));
  assign topData    = mem[topIndex];

  always_ff @(posedge clock) begin
    if (!resetN || clear) begin
      count <= '0;
    end else if (push && !full) begin
      count <= count + DEPTH_WIDTH'(1);
    end else if (pop && !empty) begin
      count <= count - DEPTH_WIDTH'(1);
    end
  end

  // Entries are never cleared; anything at or above depth is don't-care.
  always_ff @(posedge clock) begin
    if (push && !full) begin
      mem[writeIndex] <= pushData;
    end
  end

endmodule

// File: rtl/pc_stack_unit.sv
// pc_stack_unit
// Program counter with a hardware return stack, placed between instruction
// decode and the instruction-memory address port.
//   clock, resetN    : rising-edge clock, synchronous active-low reset
//   stall            : hold all state and ignore the opcode
//   opcode           : decoded instruction (pc_pkg::opcode_e encodings)
//   instructionValue : absolute target, or signed offset for RJUMP
//   registerValue    : condition operand for IF0JUMP / IF1JUMP
//   pc               : current program counter
//   stackDepth       : number of valid return entries
//   overflow         : sticky, CALL seen with a full stack
//   underflow        : sticky, RET seen with an empty stack
//   irq, irqAck      : level interrupt request / one-cycle entry pulse
// Optional feature macro: PC_IRQ_EN (interrupt entry, RETI, irq/irqAck ports).
module pc_stack_unit
  import pc_pkg::*;
#(
  parameter int                  PC_WIDTH     = 8,
  parameter int                  STACK_DEPTH  = 16,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
`ifdef PC_IRQ_EN
  ,
  parameter logic [PC_WIDTH-1:0] IRQ_VECTOR   = 'h80
`endif
) (
  input  logic                             clock,
  input  logic                             resetN,
  input  logic                             stall,
  input  logic [OPCODE_WIDTH-1:0]          opcode,
  input  logic [VALUE_WIDTH-1:0]           instructionValue,
  input  logic [REGISTER_WIDTH-1:0]        registerValue,
  output logic [PC_WIDTH-1:0]              pc,
  output logic [$clog2(STACK_DEPTH+1)-1:0] stackDepth,
  output logic                             overflow,
  output logic                             underflow
`ifdef PC_IRQ_EN
  ,
  input  logic                             irq,
  output logic                             irqAck
`endif
);

  logic [PC_WIDTH-1:0] pcPlusOne;
  logic [PC_WIDTH-1:0] absTarget;
  logic [PC_WIDTH-1:0] relTarget;
  logic [PC_WIDTH-1:0] nextPc;
  logic [PC_WIDTH-1:0] pushData;
  logic [PC_WIDTH-1:0] topData;
  logic                push;
  logic                pop;
  logic                clearReq;
  logic                setOverflow;
  logic                setUnderflow;
  logic                stackFull;
  logic                stackEmpty;
  logic [PC_WIDTH+VALUE_WIDTH-1:0] zeroExt;
  logic [PC_WIDTH+VALUE_WIDTH-1:0] signExt;
`ifdef PC_IRQ_EN
  logic                inIsr;
  logic                takeIrq;
  logic                leaveIsr;
`endif

  // Extending to the combined width first handles both widening and truncation.
  assign zeroExt   = {{PC_WIDTH{1'b0}}, instructionValue};
  assign signExt   = {{PC_WIDTH{instructionValue[VALUE_WIDTH-1]}}, instructionValue};
  assign absTarget = zeroExt[PC_WIDTH-1:0];
  assign relTarget = pc + signExt[PC_WIDTH-1:0];
  assign pcPlusOne = pc + PC_WIDTH'(1);

  always_comb begin
    nextPc       = pcPlusOne;
    pushData     = pcPlusOne;
    push         = 1'b0;
    pop          = 1'b0;
    clearReq     = 1'b0;
    setOverflow  = 1'b0;
    setUnderflow = 1'b0;
`ifdef PC_IRQ_EN
    takeIrq      = 1'b0;
    leaveIsr     = 1'b0;
    // An interrupt pre-empts the opcode and saves the not-yet-executed pc.
    if (irq && !inIsr && !stackFull) begin
      takeIrq  = 1'b1;
      push     = 1'b1;
      pushData = pc;
      nextPc   = IRQ_VECTOR;
    end else
`endif
    begin
      case (opcode)
        JUMP:    nextPc = absTarget;
        RJUMP:   nextPc = relTarget;
        IF0JUMP: nextPc = (registerValue == '0) ? absTarget : pcPlusOne;
        IF1JUMP: nextPc = (registerValue != '0) ? absTarget : pcPlusOne;
        CALL: begin
          if (stackFull) begin
            setOverflow = 1'b1;
          end else begin
            push   = 1'b1;
            nextPc = absTarget;
          end
        end
        RET: begin
          if (stackEmpty) begin
            setUnderflow = 1'b1;
          end else begin
            pop    = 1'b1;
            nextPc = topData;
          end
        end
`ifdef PC_IRQ_EN
        RETI: begin
          leaveIsr = 1'b1;
          if (stackEmpty) begin
            setUnderflow = 1'b1;
          end else begin
            pop    = 1'b1;
            nextPc = topData;
          end
        end
`endif
        RESET:   clearReq = 1'b1;
        default: nextPc = pcPlusOne;
      endcase
    end
  end

  pc_return_stack #(
    .WIDTH (PC_WIDTH),
    .DEPTH (STACK_DEPTH)
  ) returnStack (
    .clock    (clock),
    .resetN   (resetN),
    .clear    (clearReq && !stall),
    .push     (push && !stall),
    .pop      (pop && !stall),
    .pushData (pushData),
    .topData  (topData),
    .depth    (stackDepth),
    .full     (stackFull),
    .empty    (stackEmpty)
  );

  always_ff @(posedge clock) begin
    if (!resetN) begin
      pc        <= RESET_VECTOR;
      overflow  <= 1'b0;
      underflow <= 1'b0;
`ifdef PC_IRQ_EN
      inIsr     <= 1'b0;
      irqAck    <= 1'b0;
`endif
    end else begin
`ifdef PC_IRQ_EN
      irqAck <= 1'b0;
`endif
      if (!stall) begin
        if (clearReq) begin
          pc        <= RESET_VECTOR;
          overflow  <= 1'b0;
          underflow <= 1'b0;
`ifdef PC_IRQ_EN
          inIsr     <= 1'b0;
`endif
        end else begin
          pc <= nextPc;
          if (setOverflow)  overflow  <= 1'b1;
          if (setUnderflow) underflow <= 1'b1;
`ifdef PC_IRQ_EN
          if (takeIrq) begin
            inIsr  <= 1'b1;
            irqAck <= 1'b1;
          end else if (leaveIsr) begin
            inIsr  <= 1'b0;
          end
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_pc_stack_unit.sv
// tb_pc_stack_unit
// Directed-vector bench for pc_stack_unit with hand-computed expectations.
// Build with PC_IRQ_EN defined to also exercise the interrupt path.
module tb_pc_stack_unit;
  import pc_pkg::*;

  logic                      clock;
  logic                      resetN;
  logic                      stall;
  logic [OPCODE_WIDTH-1:0]   opcode;
  logic [VALUE_WIDTH-1:0]    instructionValue;
  logic [REGISTER_WIDTH-1:0] registerValue;
  logic [7:0]                pc;
  logic [4:0]                stackDepth;
  logic                      overflow;
  logic                      underflow;
`ifdef PC_IRQ_EN
  logic                      irq;
  logic                      irqAck;
`endif

  int checkCount = 0;
  int errorCount = 0;

  pc_stack_unit dut (
    .clock            (clock),
    .resetN           (resetN),
    .stall            (stall),
    .opcode           (opcode),
    .instructionValue (instructionValue),
    .registerValue    (registerValue),
    .pc               (pc),
    .stackDepth       (stackDepth),
    .overflow         (overflow),
    .underflow        (underflow)
`ifdef PC_IRQ_EN
    ,
    .irq              (irq),
    .irqAck           (irqAck)
`endif
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Drive one instruction, let one rising edge pass, settle 1 time unit.
  task automatic applyStimulus(input logic [OPCODE_WIDTH-1:0] op,
                               input logic [VALUE_WIDTH-1:0] value,
                               input logic [REGISTER_WIDTH-1:0] regValue);
    opcode           = op;
    instructionValue = value;
    registerValue    = regValue;
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // From pc=0 with an empty stack: CALLs to 'h10..'h1F, leaving a full stack.
  task automatic fillStack();
    for (int i = 0; i < 16; i++) begin
      applyStimulus(CALL, 8'(8'h10 + i), 8'h00);
    end
  endtask

  initial begin
    resetN           = 1'b0;
    stall            = 1'b1;
    opcode           = NOP;
    instructionValue = '0;
    registerValue    = '0;
`ifdef PC_IRQ_EN
    irq              = 1'b0;
`endif

    // Reset wins over stall and a pending JUMP.
    applyStimulus(JUMP, 8'h40, 8'h00);
    checkOutput("reset pc", 32'(pc), 32'h00);
    checkOutput("reset depth", 32'(stackDepth), 32'd0);
    checkOutput("reset overflow", 32'(overflow), 32'd0);
    checkOutput("reset underflow", 32'(underflow), 32'd0);

    resetN = 1'b1;
    stall  = 1'b0;

    // CALL / RET round trip.
    applyStimulus(JUMP, 8'h05, 8'h00);
    checkOutput("jump pc", 32'(pc), 32'h05);
    applyStimulus(CALL, 8'h20, 8'h00);
    checkOutput("call pc", 32'(pc), 32'h20);
    checkOutput("call depth", 32'(stackDepth), 32'd1);
    applyStimulus(RET, 8'h00, 8'h00);
    checkOutput("ret pc", 32'(pc), 32'h06);
    checkOutput("ret depth", 32'(stackDepth), 32'd0);

    // Fill the stack, then overflow it.
    applyStimulus(JUMP, 8'h00, 8'h00);
    fillStack();
    checkOutput("fill pc", 32'(pc), 32'h1F);
    checkOutput("fill depth", 32'(stackDepth), 32'd16);
    checkOutput("fill overflow", 32'(overflow), 32'd0);
    applyStimulus(CALL, 8'h55, 8'h00);
    checkOutput("overflow pc", 32'(pc), 32'h20);
    checkOutput("overflow depth", 32'(stackDepth), 32'd16);
    checkOutput("overflow flag", 32'(overflow), 32'd1);

    // Unwind: entry k holds 1 for k=0, else 'h10+k.
    for (int k = 15; k >= 0; k--) begin
      applyStimulus(RET, 8'h00, 8'h00);
      checkOutput("unwind pc", 32'(pc), (k == 0) ? 32'h01 : 32'(8'h10 + k));
      checkOutput("unwind depth", 32'(stackDepth), 32'(k));
    end
    applyStimulus(RET, 8'h00, 8'h00);
    checkOutput("underflow pc", 32'(pc), 32'h02);
    checkOutput("underflow flag", 32'(underflow), 32'd1);
    checkOutput("overflow sticky", 32'(overflow), 32'd1);
    applyStimulus(NOP, 8'h00, 8'h00);
    checkOutput("underflow sticky", 32'(underflow), 32'd1);

    // RESET opcode clears pc and both flags.
    applyStimulus(RESET, 8'h77, 8'h00);
    checkOutput("opreset pc", 32'(pc), 32'h00);
    checkOutput("opreset overflow", 32'(overflow), 32'd0);
    checkOutput("opreset underflow", 32'(underflow), 32'd0);

    // Relative jumps and wrap-around.
    applyStimulus(JUMP, 8'h10, 8'h00);
    applyStimulus(RJUMP, 8'hFC, 8'h00);
    checkOutput("rjump back", 32'(pc), 32'h0C);
    applyStimulus(RJUMP, 8'h05, 8'h00);
    checkOutput("rjump fwd", 32'(pc), 32'h11);
    applyStimulus(JUMP, 8'hFF, 8'h00);
    applyStimulus(NOP, 8'h00, 8'h00);
    checkOutput("pc wrap", 32'(pc), 32'h00);

    // Conditional jumps.
    applyStimulus(IF0JUMP, 8'h30, 8'h00);
    checkOutput("if0 taken", 32'(pc), 32'h30);
    applyStimulus(IF0JUMP, 8'h40, 8'h03);
    checkOutput("if0 not taken", 32'(pc), 32'h31);
    applyStimulus(IF1JUMP, 8'h50, 8'h03);
    checkOutput("if1 taken", 32'(pc), 32'h50);
    applyStimulus(IF1JUMP, 8'h60, 8'h00);
    checkOutput("if1 not taken", 32'(pc), 32'h51);

    // Stall freezes everything, including a RESET opcode.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(CALL, 8'h70, 8'h00);
      checkOutput("stall pc", 32'(pc), 32'h51);
      checkOutput("stall depth", 32'(stackDepth), 32'd0);
    end
    applyStimulus(RESET, 8'h00, 8'h00);
    checkOutput("stall reset pc", 32'(pc), 32'h51);
    stall = 1'b0;
    applyStimulus(CALL, 8'h70, 8'h00);
    checkOutput("post-stall call pc", 32'(pc), 32'h70);
    checkOutput("post-stall depth", 32'(stackDepth), 32'd1);
    applyStimulus(RET, 8'h00, 8'h00);
    checkOutput("post-stall ret pc", 32'(pc), 32'h52);

`ifndef PC_IRQ_EN
    // Without the interrupt feature RETI is an ordinary advance.
    applyStimulus(RETI, 8'h00, 8'h00);
    checkOutput("reti default pc", 32'(pc), 32'h53);
    checkOutput("reti default depth", 32'(stackDepth), 32'd0);
`else
    // Interrupt entry and return.
    applyStimulus(JUMP, 8'h12, 8'h00);
    irq = 1'b1;
    applyStimulus(JUMP, 8'h44, 8'h00);
    checkOutput("irq pc", 32'(pc), 32'h80);
    checkOutput("irq ack", 32'(irqAck), 32'd1);
    checkOutput("irq depth", 32'(stackDepth), 32'd1);
    irq = 1'b0;
    applyStimulus(NOP, 8'h00, 8'h00);
    checkOutput("isr pc", 32'(pc), 32'h81);
    checkOutput("ack pulse", 32'(irqAck), 32'd0);
    applyStimulus(RETI, 8'h00, 8'h00);
    checkOutput("reti pc", 32'(pc), 32'h12);
    checkOutput("reti depth", 32'(stackDepth), 32'd0);

    // Interrupt held off while the stack is full.
    applyStimulus(JUMP, 8'h00, 8'h00);
    fillStack();
    irq = 1'b1;
    applyStimulus(NOP, 8'h00, 8'h00);
    checkOutput("full irq pc", 32'(pc), 32'h20);
    checkOutput("full irq ack", 32'(irqAck), 32'd0);
    applyStimulus(RET, 8'h00, 8'h00);
    checkOutput("ret before irq", 32'(pc), 32'h1F);
    checkOutput("ret before irq depth", 32'(stackDepth), 32'd15);
    applyStimulus(NOP, 8'h00, 8'h00);
    checkOutput("late irq pc", 32'(pc), 32'h80);
    checkOutput("late irq ack", 32'(irqAck), 32'd1);
    checkOutput("late irq depth", 32'(stackDepth), 32'd16);
    irq = 1'b0;
    applyStimulus(RETI, 8'h00, 8'h00);
    checkOutput("late reti pc", 32'(pc), 32'h1F);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/pc_stack_unit.md
Name: pc_stack_unit

Overview:
- Parametrised successor to the CPU program-counter block: holds the PC and a hardware return stack.
- Adds configurable PC width and stack depth, a stall input, PC-relative jumps, overflow/underflow detection and an exposed stack depth.
- Sits between instruction decode (opcode, immediate) and the instruction memory address port. The register file supplies the branch-condition value.

Parameters:
- PC_WIDTH, 8, width of the program counter and of the return-stack entries.
- STACK_DEPTH, 16, number of return-stack entries; must be ≥2.
- RESET_VECTOR, 0, PC value loaded by resetN or the RESET opcode.
- IRQ_VECTOR, 'h80, interrupt entry address (only used with PC_IRQ_EN).

Ports:
- clock  in  1  rising-edge clock.
- resetN  in  1  synchronous active-low reset.
- stall  in  1  1 = hold all state and ignore the opcode.
- opcode  in  OPCODE_WIDTH  decoded instruction opcode.
- instructionValue  in  VALUE_WIDTH  immediate: absolute target, or signed offset for RJUMP.
- registerValue  in  REGISTER_WIDTH  condition operand for IF0JUMP/IF1JUMP.
- pc  out  PC_WIDTH  current program counter.
- stackDepth  out  $clog2(STACK_DEPTH+1)  number of valid return entries.
- overflow  out  1  sticky flag: CALL attempted while the stack was full.
- underflow  out  1  sticky flag: RET attempted while the stack was empty.
- irq  in  1  level interrupt request (PC_IRQ_EN only).
- irqAck  out  1  one-cycle pulse when an interrupt is taken (PC_IRQ_EN only).

Behaviour:
- Reset: when resetN=0 at a rising edge, pc<=RESET_VECTOR, stackDepth<=0, overflow<=0, underflow<=0, irqAck<=0. Reset overrides stall and all opcodes.
- Timing: all updates are registered. The opcode sampled at edge N produces the new pc after edge N. Latency is 1 cycle, one instruction per cycle.
- Stall: when stall=1, pc, the stack, the flags and stackDepth hold. No opcode has any effect, RESET included.
- pcPlusOne = pc+1, modulo 2^PC_WIDTH; 'hFF+1 = 0 at the default width.
- Absolute target = instructionValue zero-extended or truncated to PC_WIDTH.
- RJUMP target = pc + sign-extended instructionValue, modulo 2^PC_WIDTH.
- Opcode actions:
  - JUMP: pc<=target.
  - RJUMP: pc<=relative target.
  - IF0JUMP: pc<=target if registerValue==0, else pcPlusOne.
  - IF1JUMP: pc<=target if registerValue!=0, else pcPlusOne.
  - CALL, stack not full: stack[stackDepth]<=pcPlusOne, stackDepth+1, pc<=target.
  - CALL, stack full: no push, pc<=pcPlusOne (the call is suppressed), overflow<=1.
  - RET, stack not empty: pc<=stack[stackDepth-1], stackDepth-1.
  - RET, stack empty: pc<=pcPlusOne, underflow<=1.
  - RESET: same effect as resetN=0 (pc, stackDepth and both flags cleared).
  - Any other opcode: pc<=pcPlusOne.
- Return path: the top-of-stack read is combinational from stackDepth-1, so there is no bubble on RET.
- Back-to-back CALL/RET: a RET immediately after a CALL returns the just-pushed value.
- Flags: overflow and underflow stay set until resetN or RESET.
- Stack contents are never cleared; entries at or above stackDepth are don't-care.

Optional Feature:
- Macro: PC_IRQ_EN.
- With the macro defined:
  - An interrupt is taken at an edge where resetN=1, stall=0, irq=1, not in ISR, and the stack is not full.
  - Interrupt priority: it replaces the current opcode's effect.
  - On entry: push pc (the current, not-yet-executed address), pc<=IRQ_VECTOR, inIsr<=1, irqAck=1 for one cycle.
  - Opcode RETI: pops like RET and clears inIsr.
  - An irq arriving while the stack is full waits until there is space.
  - Reset clears inIsr.
- Without the macro: the irq and irqAck ports are absent, RETI decodes as the default (pcPlusOne), and there is no interrupt logic.

Decomposition:
- Shared package pc_pkg holds:
  - opcode constants JUMP, RJUMP, CALL, RET, RETI, IF0JUMP, IF1JUMP, RESET;
  - OPCODE_WIDTH, VALUE_WIDTH, REGISTER_WIDTH.
- Sub-module pc_return_stack (parametrised LIFO):
  - inputs: push, pop, pushData;
  - outputs: topData, depth, full, empty.
  - pc_stack_unit owns the PC mux and the flags.

Test Plan:
- resetN=0 with stall=1 and opcode=JUMP 'h40 → after the edge pc=0, stackDepth=0, flags 0.
- pc=5, CALL 'h20 then RET → pc=5 → 'h20 → 6, with stackDepth 0→1→0.
- 16 nested CALLs then a 17th → 17th: pc=prev+1, stackDepth=16, overflow=1. Then 17 RETs → last RET: pc=prev+1, underflow=1.
- pc='h10, RJUMP 'hFC (VALUE_WIDTH=8) → pc='h0C. pc='hFF, default opcode → pc=0.
- IF0JUMP 'h30 with registerValue=0 → pc='h30. Same with registerValue=3 → pc+1. stall=1 for 3 cycles during a CALL → no change.
- PC_IRQ_EN: pc='h12, irq=1 → pc='h80, irqAck pulse, stackDepth+1. RETI → pc='h12. irq with a full stack → not taken until after a RET.
